// File: rtl/rc_gen.sv
// rc_gen: Keccak-p round-constant generator.
// The rc(t) LFSR runs on the fly instead of reading a fixed constant table,
// so one block serves every lane width W in {8,16,32,64}. Each round takes
// 7 LFSR steps, and those steps are unrolled combinationally.
// Optional feature macro: RCGEN_REDUCED_EN. It adds the nr_i port and the
// SEEK state, so a schedule can start part-way through (Keccak-p[25W, nr]).
module rc_gen #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
`ifdef RCGEN_REDUCED_EN
  input  logic [4:0]   nr_i,
`endif
  input  logic         advance_i,
  output logic         rc_valid_o,
  output logic [W-1:0] rc_o,
  output logic [4:0]   round_o,
  output logic         last_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int         L          = $clog2(W);
  localparam int         NR         = 12 + 2 * L;
  localparam logic [4:0] NR5        = 5'(NR);
  localparam logic [4:0] LAST_ROUND = 5'(NR - 1);
  localparam logic [7:0] SEED       = 8'h01;

  localparam logic [1:0] S_IDLE = 2'd0;
`ifdef RCGEN_REDUCED_EN
  localparam logic [1:0] S_SEEK = 2'd1;
`endif
  localparam logic [1:0] S_RUN  = 2'd2;

  // One step of x^8+x^6+x^5+x^4+1. The output bit is r[0], and the bit that
  // shifts out of r[7] folds back into taps 0, 4, 5 and 6.
  function automatic logic [7:0] lfsrStep(input logic [7:0] r);
    logic [7:0] n;
    logic       f;
    f    = r[7];
    n    = {r[6:0], 1'b0};
    n[0] = n[0] ^ f;
    n[4] = n[4] ^ f;
    n[5] = n[5] ^ f;
    n[6] = n[6] ^ f;
    return n;
  endfunction

  // Advances the state by one full round, which is seven LFSR steps.
  function automatic logic [7:0] roundStep(input logic [7:0] s);
    logic [7:0] r;
    r = s;
    for (int k = 0; k < 7; k++) begin
      r = lfsrStep(r);
    end
    return r;
  endfunction

  // Spreads rc(7*ir + j) onto lane bit 2^j - 1. Every other bit is zero.
  function automatic logic [W-1:0] rcWord(input logic [7:0] s);
    logic [7:0]   r;
    logic [W-1:0] word;
    r    = s;
    word = '0;
    for (int j = 0; j <= L; j++) begin
      word[(1 << j) - 1] = r[0];
      r = lfsrStep(r);
    end
    return word;
  endfunction

  logic [1:0]   r_state;
  logic [7:0]   r_lfsr;
  logic [4:0]   r_round;
  logic         r_done;
  logic         w_valid;
  logic         w_last;
  logic [7:0]   w_lfsrNext;
  logic [W-1:0] w_rcRaw;

`ifdef RCGEN_REDUCED_EN
  logic [4:0]   r_first;
  logic [4:0]   w_first;

  // Maps the requested round count to a first-round index. Zero, and any
  // value above NR, both mean a full schedule.
  always_comb begin
    w_first = 5'd0;
    if (nr_i != 5'd0 && nr_i <= NR5) begin
      w_first = NR5 - nr_i;
    end
  end
`endif

  // Combinational round unroll and constant formation from the registered state.
  always_comb begin
    w_lfsrNext = roundStep(r_lfsr);
    w_rcRaw    = rcWord(r_lfsr);
    w_valid    = (r_state == S_RUN);
    w_last     = w_valid && (r_round == LAST_ROUND);
  end

  // Schedule controller: IDLE -> (SEEK) -> RUN -> IDLE.
  // The LFSR is reseeded on every start and again when a schedule finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_round <= 5'd0;
      r_done  <= 1'b0;
`ifdef RCGEN_REDUCED_EN
      r_first <= 5'd0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_lfsr  <= SEED;
            r_round <= 5'd0;
`ifdef RCGEN_REDUCED_EN
            r_first <= w_first;
            r_state <= (w_first == 5'd0) ? S_RUN : S_SEEK;
`else
            r_state <= S_RUN;
`endif
          end
        end
`ifdef RCGEN_REDUCED_EN
        S_SEEK: begin
          r_lfsr  <= w_lfsrNext;
          r_round <= r_round + 5'd1;
          if (r_round + 5'd1 == r_first) begin
            r_state <= S_RUN;
          end
        end
`endif
        S_RUN: begin
          if (advance_i) begin
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_round <= 5'd0;
              r_lfsr  <= SEED;
            end else begin
              r_lfsr  <= w_lfsrNext;
              r_round <= r_round + 5'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rc_valid_o = w_valid;
  assign rc_o       = w_valid ? w_rcRaw : '0;
  assign round_o    = r_round;
  assign last_o     = w_last;
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = r_done;

endmodule

// File: doc/rc_gen.md
# rc_gen

Sequential, parametrised Keccak-p round-constant generator. It replaces a fixed 24-entry constant table with the on-the-fly rc(t) LFSR, so one block serves every lane width from 8 to 64 bits and, optionally, reduced-round permutations that start mid-schedule. It sits beside the iota step of the permutation datapath. It supplies one constant per round through a valid/advance handshake and flags the final round.

## Interface
- `W`, default 64, lane width; legal values 8, 16, 32, 64. Derived: `L = log2(W)`, `NR = 12 + 2L`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start_i`  in  1  begin a new schedule; honoured only in IDLE.
- `nr_i`  in  5  number of rounds to run; present only with `RCGEN_REDUCED_EN`.
- `advance_i`  in  1  consumer has used the current constant.
- `rc_valid_o`  out  1  `rc_o` holds a valid constant.
- `rc_o`  out  W  round constant for `round_o`.
- `round_o`  out  5  absolute round index ir, from 0 to NR-1.
- `last_o`  out  1  current constant is the final round (ir = NR-1).
- `busy_o`  out  1  the block is not in IDLE.
- `done_o`  out  1  one-cycle pulse after the final constant is consumed.

## Operation
- The LFSR is 8 bits and implements rc(t) with polynomial x^8+x^6+x^5+x^4+1. The schedule seed is 8'h01, giving rc(0)=1.
  - One step: the output bit is R[0]; feedback f = R[7]; R = {R[6:0],1'b0}; then R[0], R[4], R[5] and R[6] are each XORed with f.
- A round consumes 7 LFSR steps. These are unrolled combinationally: a single "round step" takes the state at t=7·ir to the state at t=7·(ir+1).
- `rc_o` is built from the registered LFSR state through the 7-step unroll.
  - `rc_o[2^j−1] = rc(7·ir + j)` for j = 0..L.
  - All other bits of `rc_o` are 0.
- The first round index is `FIRST = NR − nr_eff`. Without the macro, `nr_eff = NR`.
- States:
  - IDLE: outputs quiet. On `start_i`: load LFSR to 8'h01 and set `round_o` to 0. If FIRST = 0 go to RUN, otherwise go to SEEK.
  - SEEK: each cycle apply one round step and increment `round_o`. When `round_o` reaches FIRST, go to RUN. `rc_valid_o` stays 0 and `busy_o` stays 1.
  - RUN: `rc_valid_o` = 1. On `advance_i`:
    - If `last_o` is 1, go to IDLE and pulse `done_o`.
    - Otherwise apply one round step and increment `round_o`. `rc_valid_o` stays 1.
- `advance_i` has no effect while `rc_valid_o` is 0. `start_i` has no effect while `busy_o` is 1. If both are asserted on the final-round cycle, `advance_i` wins and `start_i` is dropped.
- Reset at any point returns the block to IDLE. Reset values of all outputs:
  - `rc_valid_o`, `last_o`, `busy_o`, `done_o` = 0.
  - `round_o` = 0.
  - LFSR = 8'h01.
  - `rc_o` = 0, because it is gated by valid.

## Timing
- `start_i` sampled at edge 0 with FIRST = 0: `rc_valid_o` = 1 with round 0 after edge 0.
- With FIRST = k > 0: k SEEK cycles, then `rc_valid_o` rises after edge k.
- In RUN, each accepted `advance_i` produces the next constant on the following cycle. There are no bubbles, so back-to-back advances give one round per cycle.
- `done_o` is high for the single cycle after the final advance edge. `busy_o` falls in that same cycle.
- `rc_o`, `round_o` and `last_o` are stable while `rc_valid_o` is 1 and `advance_i` is 0.

## Configuration
- `RCGEN_REDUCED_EN` defined:
  - The `nr_i` port exists and is latched on `start_i`.
  - `nr_eff` is `nr_i`. The values 0 and anything above NR are clamped to NR.
  - SEEK is reachable; the block runs the last `nr_eff` rounds of Keccak-f, i.e. Keccak-p[25W, nr].
- `RCGEN_REDUCED_EN` undefined:
  - No `nr_i` port; `nr_eff = NR`.
  - The SEEK state is not synthesised, and every schedule starts at round 0.

## Test plan
- W=64, start, advance every cycle: round 0 = 64'h0000000000000001, round 1 = 64'h0000000000008082, round 23 = 64'h8000000080008008. `last_o` is 1 only at round 23; `done_o` pulses once, 25 cycles after start.
- W=32: 22 rounds. Round 2 = 32'h0000808A and round 3 = 32'h80008000. `last_o` is set at round 21.
- W=8: 18 rounds. Round 1 = 8'h82 and round 2 = 8'h8A; all bits other than 0, 1, 3 and 7 stay 0.
- `RCGEN_REDUCED_EN`, W=64, nr_i=12:
  - 12 SEEK cycles, then `rc_valid_o` at edge 12 with `round_o` = 12 and `rc_o` = 64'h000000008000808B.
  - 12 rounds are emitted; `nr_i=0` runs the full 24.
- Hold `advance_i` low for 5 cycles in RUN: outputs frozen. Pulse `start_i` mid-run: ignored, and the sequence continues unchanged.
- Drop `rst_n` during round 7 (also in SEEK when the macro is on): all outputs 0 immediately. A following start restarts at round 0 with 64'h1.
